// File: rtl/adc108s102_emulator.sv
// Emulates the serial side of an ADC108S102: 8 channels, 10-bit results, SPI mode 3 framing.
// Define ADC_EMU_TRISTATE_EN to float dout while deselected or in reset; otherwise it is driven low.
module adc108s102_emulator #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cs_n,
    input  logic        sclk,
    input  logic        din,
    input  logic [79:0] ch_value,
    output logic        dout,
    output logic        frame_done,
    output logic        short_frame,
    output logic [2:0]  cur_addr
);

    // cs_n and sclk chains carry one extra flop holding the previous synchronized value
    logic [SYNC_STAGES:0]   cs_sync_q;
    logic [SYNC_STAGES:0]   sclk_sync_q;
    logic [SYNC_STAGES-1:0] din_sync_q;

    logic [4:0]  cnt_q, cnt_d;
    logic [15:0] shift_q, shift_d;
    logic [2:0]  cur_addr_q, cur_addr_d;
    logic [2:0]  next_addr_q, next_addr_d;
    logic        frame_done_q, frame_done_d;
    logic        short_frame_q, short_frame_d;

    logic        cs_s, cs_prev, sclk_s, sclk_prev, din_s;
    logic        cs_fall, cs_rise, sclk_rise, sclk_fall;
    logic [4:0]  cnt_inc;
    logic [15:0] load_word;
    logic [9:0]  ch_arr [8];

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_ch
            assign ch_arr[gi] = ch_value[10*gi +: 10];
        end
    endgenerate

    assign cs_s      = cs_sync_q[SYNC_STAGES-1];
    assign cs_prev   = cs_sync_q[SYNC_STAGES];
    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign sclk_prev = sclk_sync_q[SYNC_STAGES];
    assign din_s     = din_sync_q[SYNC_STAGES-1];

    assign cs_fall   = cs_prev & ~cs_s;
    assign cs_rise   = ~cs_prev & cs_s;
    assign sclk_rise = ~sclk_prev & sclk_s;
    assign sclk_fall = sclk_prev & ~sclk_s;

    assign cnt_inc   = cnt_q + 5'd1;
    assign load_word = {4'b0000, ch_arr[cur_addr_q], 2'b00};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs_sync_q   <= '1;
            sclk_sync_q <= '1;
            din_sync_q  <= '0;
        end else begin
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-1:0], cs_n};
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-1:0], sclk};
            din_sync_q  <= {din_sync_q[SYNC_STAGES-2:0], din};
        end
    end

    // cs_n rise wins over any sclk edge seen in the same cycle
    always_comb begin
        cnt_d         = cnt_q;
        shift_d       = shift_q;
        cur_addr_d    = cur_addr_q;
        next_addr_d   = next_addr_q;
        frame_done_d  = 1'b0;
        short_frame_d = 1'b0;
        if (cs_rise) begin
            if (cnt_q != 5'd0 && cnt_q != 5'd16) begin
                short_frame_d = 1'b1;
            end
            cnt_d = 5'd0;
        end else if (cs_fall) begin
            cnt_d   = 5'd0;
            shift_d = load_word;
        end else if (!cs_s) begin
            if (sclk_rise && cnt_q != 5'd16) begin
                cnt_d = cnt_inc;
                case (cnt_inc)
                    5'd3:    next_addr_d[2] = din_s;
                    5'd4:    next_addr_d[1] = din_s;
                    5'd5:    next_addr_d[0] = din_s;
                    default: ;
                endcase
                if (cnt_inc == 5'd16) begin
                    frame_done_d = 1'b1;
                    cur_addr_d   = next_addr_q;
                end
            end else if (sclk_fall) begin
                // The falling edge ahead of the first rising edge keeps the MSB on the line
                if (cnt_q == 5'd16) begin
                    cnt_d   = 5'd0;
                    shift_d = load_word;
                end else if (cnt_q != 5'd0) begin
                    shift_d = {shift_q[14:0], 1'b0};
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q         <= '0;
            shift_q       <= '0;
            cur_addr_q    <= '0;
            next_addr_q   <= '0;
            frame_done_q  <= 1'b0;
            short_frame_q <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            shift_q       <= shift_d;
            cur_addr_q    <= cur_addr_d;
            next_addr_q   <= next_addr_d;
            frame_done_q  <= frame_done_d;
            short_frame_q <= short_frame_d;
        end
    end

    assign frame_done  = frame_done_q;
    assign short_frame = short_frame_q;
    assign cur_addr    = cur_addr_q;

`ifdef ADC_EMU_TRISTATE_EN
    assign dout = (!rst_n || cs_s) ? 1'bz : shift_q[15];
`else
    assign dout = (!rst_n || cs_s) ? 1'b0 : shift_q[15];
`endif

endmodule
